// File: rtl/status_register.sv
// 6502 processor status register (P) with push byte and a delayed IRQ mask.
module status_register #(
  parameter logic [7:0] RESET_P        = 8'h24,
  parameter bit         CLEAR_D_ON_INT = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] alu_flags,
  input  logic [7:0] alu_flags_ena,
  input  logic [2:0] flag_op,
  input  logic       p_load,
  input  logic [7:0] p_load_data,
  input  logic       int_entry,
  input  logic       sync,
  input  logic       push_brk,
  output logic [7:0] flags,
  output logic [7:0] push_data,
  output logic       irq_mask
);

  localparam int unsigned W = 8;

  // Bits 7,6,3,2,1,0 are storage; bit 5 reads 1, bit 4 reads 0.
  localparam logic [W-1:0] WR_MASK  = 8'hCF;
  localparam logic [W-1:0] FIXED_P  = 8'h20;
  localparam logic [W-1:0] RESET_PV = (RESET_P & WR_MASK) | FIXED_P;

  localparam int unsigned BIT_C = 0;
  localparam int unsigned BIT_I = 2;
  localparam int unsigned BIT_D = 3;
  localparam int unsigned BIT_V = 6;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_CLC  = 3'd1,
    OP_SEC  = 3'd2,
    OP_CLI  = 3'd3,
    OP_SEI  = 3'd4,
    OP_CLV  = 3'd5,
    OP_CLD  = 3'd6,
    OP_SED  = 3'd7
  } flag_op_e;

  logic [W-1:0] p_q;
  logic [W-1:0] p_d;
  logic [W-1:0] alu_en;
  logic         irq_mask_q;
  logic         irq_mask_d;

  // Next P: later assignments carry higher priority (ALU < flag op < int entry < pull).
  always_comb begin
    p_d    = p_q;
    alu_en = alu_flags_ena & WR_MASK;
    if (p_load) begin
      p_d = p_load_data;
    end else begin
      p_d = (p_q & ~alu_en) | (alu_flags & alu_en);
      case (flag_op_e'(flag_op))
        OP_CLC:  p_d[BIT_C] = 1'b0;
        OP_SEC:  p_d[BIT_C] = 1'b1;
        OP_CLI:  p_d[BIT_I] = 1'b0;
        OP_SEI:  p_d[BIT_I] = 1'b1;
        OP_CLV:  p_d[BIT_V] = 1'b0;
        OP_CLD:  p_d[BIT_D] = 1'b0;
        OP_SED:  p_d[BIT_D] = 1'b1;
        default: ;
      endcase
      if (int_entry) begin
        p_d[BIT_I] = 1'b1;
        if (CLEAR_D_ON_INT) p_d[BIT_D] = 1'b0;
      end
    end
    p_d = (p_d & WR_MASK) | FIXED_P;
  end

  // IRQ mask follows I only at instruction boundaries; interrupt entry masks at once.
  always_comb begin
    irq_mask_d = irq_mask_q;
    if (sync)      irq_mask_d = p_q[BIT_I];
    if (int_entry) irq_mask_d = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_q        <= RESET_PV;
      irq_mask_q <= 1'b1;
    end else begin
      p_q        <= p_d;
      irq_mask_q <= irq_mask_d;
    end
  end

  // Outputs come straight from the register with no added delay.
  assign flags     = p_q;
  assign push_data = {p_q[7:6], 1'b1, push_brk, p_q[3:0]};
  assign irq_mask  = irq_mask_q;

endmodule
